// File: rtl/uart_duplex_core.sv
// uart_duplex_core: parametrised full-duplex UART engine.
// TX path: valid/ready word input, start/data/parity/stop framing.
// RX path: 2-flop sync, mid-bit sampling, flags, FIFO output.
// Ports: clk, reset_n (sync, active low), parity_type[1:0]
//   TX: tx_data, tx_valid, tx_ready, tx_serial, tx_active, tx_done
//   RX: rx_serial, rx_data, rx_err[1:0], rx_valid, rx_ready,
//       rx_active, rx_overrun
// Option: define UART_LOOPBACK_EN to add the 'loopback' input,
// which routes internal TX into RX and parks the tx_serial pin high.
module uart_duplex_core #(
  parameter int DATA_BITS     = 8,
  parameter int CLKS_PER_BIT  = 434,
  parameter int STOP_BITS     = 1,
  parameter int RX_FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
`ifdef UART_LOOPBACK_EN
  input  logic                 loopback,
`endif
  input  logic [1:0]           parity_type,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_serial,
  output logic                 tx_active,
  output logic                 tx_done,
  input  logic                 rx_serial,
  output logic [DATA_BITS-1:0] rx_data,
  output logic [1:0]           rx_err,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_active,
  output logic                 rx_overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam int AW = $clog2(RX_FIFO_DEPTH);
  localparam int EW = DATA_BITS + 2;

  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } uart_state_t;

  // ---------------- TX ----------------
  uart_state_t tx_state, tx_next;
  logic [CW-1:0] tx_cnt;
  logic [BW-1:0] tx_bit;
  logic [DATA_BITS-1:0] tx_shift;
  logic tx_par_en;
  logic tx_par_bit;
  logic tx_tick;
  logic tx_last_stop;
  logic tx_accept;
  logic tx_line;

  assign tx_tick = (tx_cnt == CNT_LAST);

  // The last stop cycle doubles as an idle cycle so a
  // waiting word can start with no gap.
  assign tx_last_stop = (tx_state == S_STOP) && tx_tick &&
                        (tx_bit == STOP_LAST);
  assign tx_ready  = (tx_state == S_IDLE) || tx_last_stop;
  assign tx_accept = tx_valid && tx_ready;
  assign tx_done   = tx_last_stop;
  assign tx_active = (tx_state != S_IDLE);

  always_comb begin
    tx_next = tx_state;
    tx_line = 1'b1;
    unique case (tx_state)
      S_IDLE: begin
        if (tx_accept) tx_next = S_START;
      end
      S_START: begin
        tx_line = 1'b0;
        if (tx_tick) tx_next = S_DATA;
      end
      S_DATA: begin
        tx_line = tx_shift[0];
        if (tx_tick && tx_bit == DATA_LAST)
          tx_next = tx_par_en ? S_PAR : S_STOP;
      end
      S_PAR: begin
        tx_line = tx_par_bit;
        if (tx_tick) tx_next = S_STOP;
      end
      S_STOP: begin
        if (tx_last_stop)
          tx_next = tx_accept ? S_START : S_IDLE;
      end
      default: tx_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tx_state   <= S_IDLE;
      tx_cnt     <= '0;
      tx_bit     <= '0;
      tx_shift   <= '0;
      tx_par_en  <= 1'b0;
      tx_par_bit <= 1'b0;
    end else begin
      tx_state <= tx_next;
      if (tx_accept) begin
        tx_cnt     <= '0;
        tx_bit     <= '0;
        tx_shift   <= tx_data;
        tx_par_en  <= parity_type[0] ^ parity_type[1];
        tx_par_bit <= (^tx_data) ^ (parity_type == 2'b01);
      end else if (tx_state != S_IDLE) begin
        tx_cnt <= tx_tick ? '0 : tx_cnt + CW'(1);
        if (tx_tick && tx_state == S_DATA) begin
          tx_shift <= tx_shift >> 1;
          tx_bit   <= (tx_bit == DATA_LAST) ? '0 : tx_bit + BW'(1);
        end
        if (tx_tick && tx_state == S_STOP)
          tx_bit <= tx_bit + BW'(1);
      end
    end
  end

  // ---------------- line routing ----------------
  logic rx_in;

`ifdef UART_LOOPBACK_EN
  logic lb_q;

  always_ff @(posedge clk) begin
    if (!reset_n) lb_q <= 1'b0;
    else          lb_q <= loopback;
  end

  assign rx_in     = lb_q ? tx_line : rx_serial;
  assign tx_serial = lb_q ? 1'b1 : tx_line;
`else
  assign rx_in     = rx_serial;
  assign tx_serial = tx_line;
`endif

  // ---------------- RX ----------------
  uart_state_t rx_state, rx_next;
  logic rx_meta;
  logic rx_sync;
  logic rx_prev;
  logic [CW-1:0] rx_cnt;
  logic [BW-1:0] rx_bit;
  logic [DATA_BITS-1:0] rx_shift;
  logic rx_par_en;
  logic rx_par_odd;
  logic rx_perr;
  logic rx_fall;
  logic rx_smp;
  logic rx_push;
  logic [EW-1:0] push_word;

  assign rx_fall = rx_prev && !rx_sync;

  // First sample lands mid start bit, the rest a bit period apart.
  assign rx_smp = (rx_state == S_START) ? (rx_cnt == CNT_HALF)
                                        : (rx_cnt == CNT_LAST);
  assign rx_push   = (rx_state == S_STOP) && rx_smp;
  assign push_word = {!rx_sync, rx_perr, rx_shift};
  assign rx_active = (rx_state != S_IDLE);

  always_comb begin
    rx_next = rx_state;
    unique case (rx_state)
      S_IDLE: begin
        if (rx_fall) rx_next = S_START;
      end
      S_START: begin
        if (rx_smp) rx_next = rx_sync ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (rx_smp && rx_bit == DATA_LAST)
          rx_next = rx_par_en ? S_PAR : S_STOP;
      end
      S_PAR: begin
        if (rx_smp) rx_next = S_STOP;
      end
      S_STOP: begin
        if (rx_smp) rx_next = S_IDLE;
      end
      default: rx_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rx_meta    <= 1'b1;
      rx_sync    <= 1'b1;
      rx_prev    <= 1'b1;
      rx_state   <= S_IDLE;
      rx_cnt     <= '0;
      rx_bit     <= '0;
      rx_shift   <= '0;
      rx_par_en  <= 1'b0;
      rx_par_odd <= 1'b0;
      rx_perr    <= 1'b0;
    end else begin
      rx_meta  <= rx_in;
      rx_sync  <= rx_meta;
      rx_prev  <= rx_sync;
      rx_state <= rx_next;
      if (rx_state == S_IDLE) begin
        rx_cnt  <= '0;
        rx_bit  <= '0;
        rx_perr <= 1'b0;
        if (rx_fall) begin
          rx_par_en  <= parity_type[0] ^ parity_type[1];
          rx_par_odd <= (parity_type == 2'b01);
        end
      end else begin
        rx_cnt <= rx_smp ? '0 : rx_cnt + CW'(1);
        if (rx_smp && rx_state == S_DATA) begin
          rx_shift <= {rx_sync, rx_shift[DATA_BITS-1:1]};
          rx_bit   <= (rx_bit == DATA_LAST) ? '0 : rx_bit + BW'(1);
        end
        if (rx_smp && rx_state == S_PAR)
          rx_perr <= rx_sync ^ (^rx_shift) ^ rx_par_odd;
      end
    end
  end

  // ---------------- RX FIFO ----------------
  logic [EW-1:0] fifo_mem [RX_FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic fifo_empty;
  logic fifo_full;
  logic rx_pop;
  logic fifo_wr;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rx_valid = !fifo_empty;
  assign rx_pop   = rx_valid && rx_ready;

  // A same-cycle pop frees the slot the push needs.
  assign fifo_wr = rx_push && (!fifo_full || rx_pop);

  assign {rx_err, rx_data} = fifo_empty ? '0
                           : fifo_mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (fifo_wr) fifo_mem[wr_ptr[AW-1:0]] <= push_word;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      rx_overrun <= 1'b0;
    end else begin
      if (fifo_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (rx_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      rx_overrun <= rx_push && fifo_full && !rx_pop;
    end
  end

endmodule

// File: tb/tb_uart_duplex_core.sv
// tb_uart_duplex_core: directed bench for uart_duplex_core.
// CLKS_PER_BIT=16, DATA_BITS=8, STOP_BITS=1, RX_FIFO_DEPTH=4.
`timescale 1ns/1ps
module tb_uart_duplex_core;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] parity_type;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_serial;
  logic       tx_active;
  logic       tx_done;
  logic       rx_serial;
  logic [7:0] rx_data;
  logic [1:0] rx_err;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_active;
  logic       rx_overrun;
`ifdef UART_LOOPBACK_EN
  logic       loopback;
`endif

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int ov_cnt = 0;
  int t_rise = 0;
  logic rv_q = 1'b0;

  logic [10:0] bits;
  int done_at;
  int nd;
  logic rdy;
  logic r1;
  int t0;
  int lat;
  int ov0;

  uart_duplex_core #(
    .DATA_BITS    (8),
    .CLKS_PER_BIT (CPB),
    .STOP_BITS    (1),
    .RX_FIFO_DEPTH(4)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
`ifdef UART_LOOPBACK_EN
    .loopback   (loopback),
`endif
    .parity_type(parity_type),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_serial  (tx_serial),
    .tx_active  (tx_active),
    .tx_done    (tx_done),
    .rx_serial  (rx_serial),
    .rx_data    (rx_data),
    .rx_err     (rx_err),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .rx_active  (rx_active),
    .rx_overrun (rx_overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_overrun) ov_cnt <= ov_cnt + 1;
    if (rx_valid && !rv_q) t_rise <= cyc;
    rv_q <= rx_valid;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] d,
                            input logic pen,
                            input logic pbit,
                            input logic sbit);
    rx_serial = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_serial = d[i];
      repeat (CPB) @(negedge clk);
    end
    if (pen) begin
      rx_serial = pbit;
      repeat (CPB) @(negedge clk);
    end
    rx_serial = sbit;
    repeat (CPB) @(negedge clk);
    rx_serial = 1'b1;
  endtask

  task automatic pop_check(input string tag,
                           input logic [7:0] d,
                           input logic [1:0] e);
    check({tag, "_valid"}, rx_valid, 1);
    check({tag, "_data"}, rx_data, d);
    check({tag, "_err"}, rx_err, e);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  // Sends one word and samples the pin mid-bit; unused bits stay 1.
  task automatic tx_frame(input logic [7:0] d,
                          input logic [1:0] pt,
                          input int nb,
                          output logic [10:0] b,
                          output int dat,
                          output logic rdy_d,
                          output logic rdy_1,
                          output int ndone);
    b = '1;
    dat = -1;
    rdy_d = 1'b0;
    rdy_1 = 1'b1;
    ndone = 0;
    tx_data = d;
    parity_type = pt;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data = ~d;
    for (int k = 1; k <= nb * CPB; k++) begin
      if (k == 1) rdy_1 = tx_ready;
      if ((k - 1) % CPB == CPB / 2) b[(k - 1) / CPB] = tx_serial;
      if (tx_done) begin
        ndone++;
        if (dat < 0) begin
          dat = k;
          rdy_d = tx_ready;
        end
      end
      @(negedge clk);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    parity_type = 2'b00;
    tx_data = 8'h00;
    tx_valid = 1'b0;
    rx_serial = 1'b1;
    rx_ready = 1'b0;
`ifdef UART_LOOPBACK_EN
    loopback = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_tx_serial", tx_serial, 1);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_tx_active", tx_active, 0);
    check("rst_tx_done", tx_done, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_active", rx_active, 0);
    check("rst_rx_overrun", rx_overrun, 0);
    check("rst_rx_data", {rx_err, rx_data}, 0);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    // TX A5, even parity
    tx_frame(8'hA5, 2'b10, 11, bits, done_at, rdy, r1, nd);
    check("tx_a5_bits", bits, {1'b1, 1'b0, 8'hA5, 1'b0});
    check("tx_a5_done_cyc", done_at, 176);
    check("tx_a5_rdy_at_done", rdy, 1);
    check("tx_a5_rdy_drop", r1, 0);
    check("tx_a5_done_width", nd, 1);
    check("tx_a5_idle", tx_active, 0);

    // TX A5, odd parity
    tx_frame(8'hA5, 2'b01, 11, bits, done_at, rdy, r1, nd);
    check("tx_a5_odd_bits", bits, {1'b1, 1'b1, 8'hA5, 1'b0});

    // TX 01, parity_type 11 means no parity
    tx_frame(8'h01, 2'b11, 10, bits, done_at, rdy, r1, nd);
    check("tx_nopar_bits", bits, {1'b1, 1'b1, 8'h01, 1'b0});
    check("tx_nopar_done_cyc", done_at, 160);

    // RX 3C, odd parity
    parity_type = 2'b01;
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    pop_check("rx_3c", 8'h3C, 2'b00);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    pop_check("rx_perr", 8'h3C, 2'b01);
    send_frame(8'h3C, 1'b1, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    pop_check("rx_serr", 8'h3C, 2'b10);
    check("rx_drained", rx_valid, 0);

    // Glitch
    rx_serial = 1'b0;
    repeat (5) @(negedge clk);
    rx_serial = 1'b1;
    check("glitch_active", rx_active, 1);
    repeat (2 * CPB) @(negedge clk);
    check("glitch_idle", rx_active, 0);
    check("glitch_no_push", rx_valid, 0);

    // Overrun: five frames, no pops
    parity_type = 2'b00;
    ov0 = ov_cnt;
    t0 = cyc;
    send_frame(8'h01, 1'b0, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    lat = t_rise - t0;
    check("rx_push_in_stop", (lat >= 150 && lat <= 160), 1);
    for (int i = 2; i <= 4; i++) begin
      send_frame(8'(i), 1'b0, 1'b0, 1'b1);
      repeat (4) @(negedge clk);
    end
    check("ovr_none_yet", ov_cnt - ov0, 0);
    send_frame(8'h05, 1'b0, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    check("ovr_one_pulse", ov_cnt - ov0, 1);
    for (int i = 1; i <= 4; i++)
      pop_check("ovr_pop", 8'(i), 2'b00);
    check("ovr_drained", rx_valid, 0);

    // Full FIFO with a pop in the push cycle
    ov0 = ov_cnt;
    for (int i = 1; i <= 4; i++) begin
      send_frame(8'(i), 1'b0, 1'b0, 1'b1);
      repeat (4) @(negedge clk);
    end
    fork
      send_frame(8'h05, 1'b0, 1'b0, 1'b1);
      begin
        repeat (lat - 1) @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
      end
    join
    repeat (4) @(negedge clk);
    check("simpop_no_ovr", ov_cnt - ov0, 0);
    for (int i = 2; i <= 5; i++)
      pop_check("simpop_pop", 8'(i), 2'b00);
    check("simpop_drained", rx_valid, 0);

    // Reset in the middle of TX and RX frames
    send_frame(8'h77, 1'b0, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    parity_type = 2'b10;
    tx_data = 8'h5A;
    tx_valid = 1'b1;
    rx_serial = 1'b0;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (20) @(negedge clk);
    check("mid_tx_bit0", tx_serial, 0);
    check("mid_rx_active", rx_active, 1);
    check("mid_fifo_held", rx_valid, 1);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("mrst_tx_serial", tx_serial, 1);
    check("mrst_tx_ready", tx_ready, 1);
    check("mrst_rx_valid", rx_valid, 0);
    check("mrst_rx_active", rx_active, 0);
    rx_serial = 1'b1;
    repeat (200) @(negedge clk);
    check("mrst_quiet", rx_valid, 0);

`ifdef UART_LOOPBACK_EN
    loopback = 1'b1;
    @(negedge clk);
    tx_frame(8'h5A, 2'b10, 11, bits, done_at, rdy, r1, nd);
    check("lb_pin_high", bits, 11'h7FF);
    check("lb_done_cyc", done_at, 176);
    repeat (4) @(negedge clk);
    pop_check("lb_5a", 8'h5A, 2'b00);
    loopback = 1'b0;
`else
    fork
      tx_frame(8'h5A, 2'b10, 11, bits, done_at, rdy, r1, nd);
      send_frame(8'h5A, 1'b1, 1'b0, 1'b1);
    join
    check("post_tx_bits", bits, {1'b1, 1'b0, 8'h5A, 1'b0});
    check("post_done_cyc", done_at, 176);
    repeat (4) @(negedge clk);
    pop_check("post_rx_5a", 8'h5A, 2'b00);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
